// File: rtl/anita4_trig_pkg.sv
// anita4_trig_pkg: shared FSM states, counter width and sizing helper for the buffer manager
package anita4_trig_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLDOFF, ST_FULL} state_t;
  localparam int LOST_W = 16;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/anita4_holdoff_counter.sv
// anita4_holdoff_counter: loadable down-counter that parks at zero and flags it
module anita4_holdoff_counter #(
  parameter int W = 5
) (
  input  logic         clk250_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk250_i) begin
    if (rst_i) cnt <= '0;
    else if (load_i) cnt <= load_val_i;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero_o = (cnt == '0);
endmodule

// File: rtl/anita4_buffer_manager.sv
// anita4_buffer_manager: round-robin LAB hold-buffer allocation, in-order release, deadtime and lost-trigger count
module anita4_buffer_manager
  import anita4_trig_pkg::*;
#(
  parameter int NUM_BUF  = 4,
  parameter int NUM_TRIG = 4,
  parameter int HOLDOFF  = 16,
  localparam int BUF_BITS = clog2(NUM_BUF)
) (
  input  logic                clk250_i,
  input  logic                rst_i,
  input  logic [NUM_TRIG-1:0] trig_i,
  input  logic [NUM_TRIG-1:0] trig_mask_i,
  input  logic                clear_i,
  input  logic [BUF_BITS-1:0] clear_buffer_i,
  output logic                digitize_o,
  output logic [BUF_BITS-1:0] digitize_buffer_o,
  output logic [NUM_TRIG-1:0] digitize_source_o,
  output logic [NUM_BUF-1:0]  buffer_status_o,
  output logic [NUM_BUF-1:0]  HOLD_o,
  output logic                dead_o,
  output logic                clear_err_o,
  output logic [LOST_W-1:0]   lost_count_o
);
  localparam int CW = clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
  localparam logic [BUF_BITS-1:0] LAST = BUF_BITS'(NUM_BUF - 1);
  state_t state, state_nx;
  logic [BUF_BITS-1:0] wr_ptr, rd_ptr;
  logic [NUM_BUF-1:0] occ, occ_nx;
  logic [NUM_TRIG-1:0] hits;
  logic hit, accept, clear_ok, ho_zero;
  // The counter loads while digitize_o is high, so the acceptance cycle adds one to the holdoff.
  anita4_holdoff_counter #(.W(CW)) u_holdoff (
    .clk250_i  (clk250_i),
    .rst_i     (rst_i),
    .load_i    (digitize_o),
    .load_val_i(HOLD_LOAD),
    .zero_o    (ho_zero)
  );
  always_comb begin
    hits = trig_i & ~trig_mask_i;
    hit = |hits;
    accept = (state == ST_IDLE) && hit && !occ[wr_ptr];
    clear_ok = clear_i && (clear_buffer_i == rd_ptr) && occ[rd_ptr];
    occ_nx = occ;
    if (clear_ok) occ_nx[rd_ptr] = 1'b0;
    if (accept) occ_nx[wr_ptr] = 1'b1;
    state_nx = state;
    if (accept) state_nx = ST_HOLDOFF;
    else if (state == ST_HOLDOFF && !digitize_o && ho_zero) state_nx = occ_nx[wr_ptr] ? ST_FULL : ST_IDLE;
    else if (state == ST_FULL && !occ_nx[wr_ptr]) state_nx = ST_IDLE;
  end
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occ               <= '0;
      digitize_o        <= 1'b0;
      digitize_buffer_o <= '0;
      digitize_source_o <= '0;
      dead_o            <= 1'b0;
      clear_err_o       <= 1'b0;
      lost_count_o      <= '0;
    end else begin
      state       <= state_nx;
      occ         <= occ_nx;
      digitize_o  <= accept;
      dead_o      <= (state_nx != ST_IDLE);
      clear_err_o <= clear_i && !clear_ok;
      if (accept) begin
        digitize_buffer_o <= wr_ptr;
        digitize_source_o <= hits;
        wr_ptr            <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (clear_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (hit && !accept && lost_count_o != '1) lost_count_o <= lost_count_o + 1'b1;
    end
  end
  assign buffer_status_o = occ;
  assign HOLD_o = occ;
endmodule

// File: tb/tb_anita4_buffer_manager.sv
// tb_anita4_buffer_manager: vector table plus hand sequences; digitize events checked against a scoreboard queue
module tb_anita4_buffer_manager;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] trig, mask;
  logic clr;
  logic [1:0] cbuf;
  logic digitize_o, dead_o, clear_err_o;
  logic [1:0] digitize_buffer_o;
  logic [3:0] digitize_source_o, buffer_status_o, HOLD_o;
  logic [15:0] lost_count_o;
  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];
  logic [5:0] exp_dig;

  anita4_buffer_manager #(.NUM_BUF(4), .NUM_TRIG(4), .HOLDOFF(16)) dut (
    .clk250_i         (clk),
    .rst_i            (rst),
    .trig_i           (trig),
    .trig_mask_i      (mask),
    .clear_i          (clr),
    .clear_buffer_i   (cbuf),
    .digitize_o       (digitize_o),
    .digitize_buffer_o(digitize_buffer_o),
    .digitize_source_o(digitize_source_o),
    .buffer_status_o  (buffer_status_o),
    .HOLD_o           (HOLD_o),
    .dead_o           (dead_o),
    .clear_err_o      (clear_err_o),
    .lost_count_o     (lost_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  trig, mask;
    logic        clr;
    logic [1:0]  cbuf;
    logic        dig;
    logic [1:0]  ebuf;
    logic [3:0]  esrc, estat;
    logic        edead, eerr;
    logic [15:0] elost;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] t, input logic [3:0] m, input logic c, input logic [1:0] cb);
    trig = t; mask = m; clr = c; cbuf = cb;
    @(posedge clk);
    @(negedge clk);
    trig = '0; mask = '0; clr = 1'b0; cbuf = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic trig_expect(input logic [3:0] t, input logic [1:0] b);
    sb.push_back({b, t});
    step(t, 4'b0000, 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (digitize_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL digitize_unexpected: got buffer %0d source %b, expected no digitize", digitize_buffer_o, digitize_source_o);
      end else begin
        exp_dig = sb.pop_front();
        check("digitize_buffer", 32'(digitize_buffer_o), 32'(exp_dig[5:4]));
        check("digitize_source", 32'(digitize_source_o), 32'(exp_dig[3:0]));
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            trig     mask     clr  cbuf dig  ebuf esrc     estat    dead eerr lost
    vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0001, 4'b0011, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0111, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1000, 4'b1111, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1, 1'b0, 16'd1};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1110, 1'b0, 1'b0, 16'd1};
    vecs[5]  = '{4'b1010, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd0, 4'b1000, 4'b1111, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1, 1'b0, 16'd1};
    vecs[7]  = '{4'b0001, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 4'b1101, 1'b0, 1'b0, 16'd2};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0001, 4'b1111, 1'b1, 1'b0, 16'd2};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 4'b1111, 1'b1, 1'b1, 16'd2};
    vecs[10] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b1011, 1'b0, 1'b0, 16'd2};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 4'b0011, 1'b0, 1'b0, 16'd2};
    vecs[12] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0, 1'b0, 16'd2};
    rst = 1'b1; trig = '0; mask = '0; clr = 1'b0; cbuf = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", 32'(buffer_status_o), 32'h0);
    check("reset_hold", 32'(HOLD_o), 32'h0);
    check("reset_dead", 32'(dead_o), 32'h0);
    check("reset_lost", 32'(lost_count_o), 32'h0);
    check("reset_digitize", 32'({digitize_o, digitize_buffer_o, digitize_source_o, clear_err_o}), 32'h0);
    rst = 1'b0;
    idle(6);
    // single trigger: 17 dead cycles starting with the digitize cycle
    trig_expect(4'b0001, 2'd0);
    check("t1_hold", 32'(HOLD_o), 32'b0001);
    check("t1_dead_accept", 32'(dead_o), 32'h1);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      check("t1_dead_holdoff", 32'(dead_o), 32'h1);
    end
    idle(1);
    check("t1_dead_end", 32'(dead_o), 32'h0);
    check("t1_buffer_held", 32'({digitize_buffer_o, digitize_source_o}), 32'({2'd0, 4'b0001}));
    idle(2);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].dig) sb.push_back({vecs[i].ebuf, vecs[i].esrc});
      step(vecs[i].trig, vecs[i].mask, vecs[i].clr, vecs[i].cbuf);
      check($sformatf("vec%0d_status", i), 32'(buffer_status_o), 32'(vecs[i].estat));
      check($sformatf("vec%0d_dead", i), 32'(dead_o), 32'(vecs[i].edead));
      check($sformatf("vec%0d_clear_err", i), 32'(clear_err_o), 32'(vecs[i].eerr));
      check($sformatf("vec%0d_lost", i), 32'(lost_count_o), 32'(vecs[i].elost));
      idle(20);
    end
    // trigger inside holdoff is lost; out-of-order clear flags an error
    trig_expect(4'b0001, 2'd2);
    idle(13);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    check("t4_no_digitize", 32'(digitize_o), 32'h0);
    check("t4_lost", 32'(lost_count_o), 32'd3);
    idle(20);
    step(4'b0000, 4'b0000, 1'b1, 2'd3);
    check("t4_clear_err", 32'(clear_err_o), 32'h1);
    check("t4_status", 32'(buffer_status_o), 32'b0110);
    idle(1);
    check("t4_clear_err_pulse", 32'(clear_err_o), 32'h0);
    // reset mid-holdoff with three buffers held
    trig_expect(4'b0001, 2'd3);
    check("t6_status_before", 32'(buffer_status_o), 32'b1110);
    idle(5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_hold", 32'(HOLD_o), 32'h0);
    check("t6_status", 32'(buffer_status_o), 32'h0);
    check("t6_dead", 32'(dead_o), 32'h0);
    check("t6_lost", 32'(lost_count_o), 32'h0);
    trig_expect(4'b0100, 2'd0);
    check("t6_next_status", 32'(buffer_status_o), 32'b0001);
    // fill every buffer, then hold a trigger for 70000 cycles to saturate the lost counter
    for (int b = 1; b < 4; b++) begin
      idle(20);
      trig_expect(4'b0001, 2'(b));
    end
    idle(20);
    check("sat_full_dead", 32'(dead_o), 32'h1);
    trig = 4'b0001;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", 32'(lost_count_o), 32'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    @(negedge clk);
    trig = '0;
    check("sat_ffff", 32'(lost_count_o), 32'hFFFF);
    idle(2);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
